str_bus_bridge: RTL and testbench
=================================

# str_bus_bridge

Parametrised stream-to-bus bridge: the next generation of the fixed 8-byte stream demux. Assembles a command, address and optional write data from a narrow ready/valid byte stream, issues one bus cycle, and for reads serialises the returned data back onto a response stream. Widths of the stream, address and data are generic. Read/write opcode and illegal-opcode reporting are new.

## Interface
- SW, 8: stream beat width; SW >= 2
- AW, 32: bus address width; AW % SW == 0
- DW, 32: bus data width; DW % SW == 0
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- str_vld  input  1  command stream valid
- str_bus  input  SW  command stream beat
- str_rdy  output  1  command stream ready
- bus_vld  output  1  bus valid (chip select)
- bus_we  output  1  1 = write, 0 = read
- bus_adr  output  AW  address
- bus_dat  output  DW  write data
- bus_rdt  input  DW  read data, valid with bus_rdy
- bus_rdy  input  1  bus ready (acknowledge)
- rsp_vld  output  1  response stream valid
- rsp_bus  output  SW  response beat
- rsp_rdy  input  1  response stream ready
- err  output  1  one-cycle pulse, illegal opcode

## Operation
- AB = AW/SW address beats, DB = DW/SW data beats. All multi-beat fields are little-endian: first beat = bits [SW-1:0].
- Packet layout: 1 command beat, then AB address beats, then DB data beats for writes only.
- Command beat bits [1:0] are the opcode: 00 write, 01 read, 1x illegal. Bits [SW-1:2] are ignored.
- FSM states:
  - CMD: str_rdy=1. On accepted beat: opcode 00/01 → ADR, latch bus_we. Illegal → err=1 next cycle, stay in CMD, beat discarded.
  - ADR: str_rdy=1. Count AB beats into bus_adr. After the last beat → DAT if write, BUS if read.
  - DAT: str_rdy=1. Count DB beats into bus_dat. After the last beat → BUS.
  - BUS: bus_vld=1, str_rdy=0. On bus_vld & bus_rdy: write → CMD; read → capture bus_rdt into a response shift register, go to RSP.
  - RSP: rsp_vld=1, rsp_bus = response register [SW-1:0]. On rsp_vld & rsp_rdy: shift right by SW. After beat DB-1 → CMD.
- Beat counter is shared by ADR/DAT/RSP, width $clog2(max(AB,DB)+1). It clears on every state change.
- bus_adr and bus_dat hold their last values outside BUS. They are stable for the whole of BUS.
- A response beat, once presented, is held stable until it is accepted.

## Timing
- Reset values: bus_vld=0, bus_we=0, bus_adr=0, bus_dat=0, rsp_vld=0, rsp_bus=0, err=0, state=CMD. str_rdy reads 1; beats offered while rst is low are ignored.
- Reset asserted mid-packet: aborts immediately. bus_vld and rsp_vld drop asynchronously and the partial packet is lost.
- bus_vld rises the cycle after the last address beat (read) or last data beat (write) is accepted.
- A write costs 1+AB+DB stream cycles plus one bus cycle, with no stall.
- rsp_vld rises the cycle after the read bus_trn.
- str_rdy rises the cycle after the write bus_trn, or the cycle after the final response beat is accepted.
- err is registered: it pulses exactly one cycle, the cycle after the illegal beat.
- str_vld may drop between beats; the counter holds.
- bus_rdy seen while bus_vld=0 is ignored.

## Structure
- package_str gains the typedef enum logic [1:0] t_op {OP_WR, OP_RD}, plus the state enum t_bridge_st.
- package_bus: no change. Widths are module parameters, not fixed structs.
- One sub-module, str_bus_ser: a parallel-load, SW-wide shift-out serialiser with a beat counter and ready/valid output. It is used for the response path.

## Test plan
Defaults SW=8, AW=32, DW=32.
- Write: beats 00,78,56,34,12,EF,BE,AD,DE back-to-back → the next cycle bus_vld=1, bus_we=1, bus_adr=0x12345678, bus_dat=0xDEADBEEF. With bus_rdy=1, str_rdy=1 on the following cycle.
- Read: 01,04,00,00,80, bus_rdy held low 3 cycles, then bus_rdt=0xCAFEF00D → bus_adr=0x80000004, bus_we=0 for 4 cycles. rsp beats 0D,F0,FE,CA on consecutive cycles with rsp_rdy=1.
- Backpressure: rsp_rdy toggling 1010… during a read response → every beat is held until accepted, order is unchanged, 8 cycles total.
- Illegal opcode: beat 02, then a write packet → err high one cycle, then a normal write as in the first test.
- Reset mid-packet: rst low after 3 address beats of a write, then a fresh read packet → no bus_vld before the read. The read completes with the new address.
- Parameters SW=16, AW=16, DW=64: write 0000,BEEF,3333,2222,1111,0000 → bus_adr=0xBEEF, bus_dat=0x0000111122223333.

Source files
------------

// File: rtl/str_bus_bridge_pkg.sv
// Shared types for the stream-to-bus bridge: opcode encoding and FSM states.
package str_bus_bridge_pkg;

    typedef enum logic [1:0] {
        OP_WR = 2'b00,
        OP_RD = 2'b01
    } t_op;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADR,
        ST_DAT,
        ST_BUS,
        ST_RSP
    } t_bridge_st;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/str_bus_ser.sv
// Parallel-load shift-out serialiser, N beats of SW bits, low beat first; first beat valid the cycle after load.
// Each beat is held until rdy; done pulses combinationally with the acceptance of the last beat.
module str_bus_ser #(
    parameter int SW = 8,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [N*SW-1:0] load_dat,
    output logic            vld,
    output logic [SW-1:0]   dat,
    input  logic            rdy,
    output logic            done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N*SW-1:0] sh;
    logic [CW-1:0]   cnt;

    assign dat  = sh[SW-1:0];
    assign done = vld & rdy & (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            cnt <= '0;
            vld <= 1'b0;
        end else if (load) begin
            sh  <= load_dat;
            cnt <= '0;
            vld <= 1'b1;
        end else if (vld && rdy) begin
            sh <= sh >> SW;
            if (done) begin
                vld <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/str_bus_bridge.sv
// Byte-stream command decoder: cmd, little-endian address and write data in, one bus cycle out,
// read data serialised back on rsp; str_rdy is low while the bus cycle or response is outstanding.
module str_bus_bridge
    import str_bus_bridge_pkg::*;
#(
    parameter int SW = 8,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          str_vld,
    input  logic [SW-1:0] str_bus,
    output logic          str_rdy,
    output logic          bus_vld,
    output logic          bus_we,
    output logic [AW-1:0] bus_adr,
    output logic [DW-1:0] bus_dat,
    input  logic [DW-1:0] bus_rdt,
    input  logic          bus_rdy,
    output logic          rsp_vld,
    output logic [SW-1:0] rsp_bus,
    input  logic          rsp_rdy,
    output logic          err
);

    localparam int AB = AW / SW;
    localparam int DB = DW / SW;
    localparam int CW = $clog2(max_int(AB, DB) + 1);
    localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    t_bridge_st    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] adr_sh;
    logic [AW-1:0] adr_nxt;
    logic [DW-1:0] dat_sh;
    logic [DW-1:0] dat_nxt;
    logic          ser_load;
    logic          ser_done;
    t_op           op;

    // Beats enter at the top and shift down, so the first beat ends up in the low bits.
    assign adr_nxt  = (adr_sh >> SW) | (AW'(str_bus) << (AW - SW));
    assign dat_nxt  = (dat_sh >> SW) | (DW'(str_bus) << (DW - SW));
    assign op       = t_op'(str_bus[1:0]);
    assign ser_load = bus_vld & bus_rdy & ~bus_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CMD;
            cnt     <= '0;
            str_rdy <= 1'b1;
            bus_vld <= 1'b0;
            bus_we  <= 1'b0;
            bus_adr <= '0;
            bus_dat <= '0;
            adr_sh  <= '0;
            dat_sh  <= '0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_CMD: begin
                    if (str_vld) begin
                        if (str_bus[1]) begin
                            err <= 1'b1;
                        end else begin
                            bus_we <= (op == OP_WR);
                            state  <= ST_ADR;
                            cnt    <= '0;
                        end
                    end
                end
                ST_ADR: begin
                    if (str_vld) begin
                        adr_sh <= adr_nxt;
                        if (cnt == AB_LAST) begin
                            cnt <= '0;
                            if (bus_we) begin
                                state <= ST_DAT;
                            end else begin
                                state   <= ST_BUS;
                                str_rdy <= 1'b0;
                                bus_vld <= 1'b1;
                                bus_adr <= adr_nxt;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_DAT: begin
                    if (str_vld) begin
                        dat_sh <= dat_nxt;
                        if (cnt == DB_LAST) begin
                            cnt     <= '0;
                            state   <= ST_BUS;
                            str_rdy <= 1'b0;
                            bus_vld <= 1'b1;
                            bus_adr <= adr_sh;
                            bus_dat <= dat_nxt;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_rdy) begin
                        bus_vld <= 1'b0;
                        cnt     <= '0;
                        if (bus_we) begin
                            state   <= ST_CMD;
                            str_rdy <= 1'b1;
                        end else begin
                            state <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (ser_done) begin
                        state   <= ST_CMD;
                        str_rdy <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state   <= ST_CMD;
                    str_rdy <= 1'b1;
                    bus_vld <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    str_bus_ser #(
        .SW (SW),
        .N  (DB)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .load_dat (bus_rdt),
        .vld      (rsp_vld),
        .dat      (rsp_bus),
        .rdy      (rsp_rdy),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_str_bus_bridge.sv
// Directed bench for str_bus_bridge: default 8/32/32 instance plus a 16/16/64 instance.
module tb_str_bus_bridge;

    logic        clk;
    logic        rst;

    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_rdy;
    logic        bus_vld;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic [31:0] bus_rdt;
    logic        bus_rdy;
    logic        rsp_vld;
    logic [7:0]  rsp_bus;
    logic        rsp_rdy;
    logic        err;

    logic        w_str_vld;
    logic [15:0] w_str_bus;
    logic        w_str_rdy;
    logic        w_bus_vld;
    logic        w_bus_we;
    logic [15:0] w_bus_adr;
    logic [63:0] w_bus_dat;
    logic [63:0] w_bus_rdt;
    logic        w_bus_rdy;
    logic        w_rsp_vld;
    logic [15:0] w_rsp_bus;
    logic        w_rsp_rdy;
    logic        w_err;

    int          n_chk;
    int          n_fail;
    logic        seen_vld;
    logic [63:0] ev;

    str_bus_bridge #(.SW(8), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy),
        .bus_vld(bus_vld), .bus_we(bus_we), .bus_adr(bus_adr), .bus_dat(bus_dat),
        .bus_rdt(bus_rdt), .bus_rdy(bus_rdy),
        .rsp_vld(rsp_vld), .rsp_bus(rsp_bus), .rsp_rdy(rsp_rdy), .err(err)
    );

    str_bus_bridge #(.SW(16), .AW(16), .DW(64)) dut_w (
        .clk(clk), .rst(rst),
        .str_vld(w_str_vld), .str_bus(w_str_bus), .str_rdy(w_str_rdy),
        .bus_vld(w_bus_vld), .bus_we(w_bus_we), .bus_adr(w_bus_adr), .bus_dat(w_bus_dat),
        .bus_rdt(w_bus_rdt), .bus_rdy(w_bus_rdy),
        .rsp_vld(w_rsp_vld), .rsp_bus(w_rsp_bus), .rsp_rdy(w_rsp_rdy), .err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Packet packed little-endian: beat i is v[8*i +: 8].
    task automatic send_a(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            seen_vld = seen_vld | bus_vld;
            str_vld  = 1'b1;
            str_bus  = v[8*i +: 8];
            tick();
        end
        str_vld = 1'b0;
    endtask

    task automatic send_b(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            w_str_vld = 1'b1;
            w_str_bus = v[16*i +: 16];
            tick();
        end
        w_str_vld = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; seen_vld = 1'b0; ev = '0;
        rst = 1'b0;
        str_vld = 1'b1; str_bus = 8'h01; bus_rdt = '0; bus_rdy = 1'b0; rsp_rdy = 1'b0;
        w_str_vld = 1'b0; w_str_bus = '0; w_bus_rdt = '0; w_bus_rdy = 1'b0; w_rsp_rdy = 1'b0;
        tick();
        tick();

        chk("rst_bus_vld", bus_vld, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_adr", bus_adr, 0);
        chk("rst_bus_dat", bus_dat, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_bus", rsp_bus, 0);
        chk("rst_err", err, 0);
        chk("rst_str_rdy", str_rdy, 1);
        chk("rst_w_bus_vld", w_bus_vld, 0);

        str_vld = 1'b0;
        rst = 1'b1;
        tick();

        // Write packet back-to-back
        bus_rdy = 1'b1;
        send_a(72'hDEADBEEF1234567800, 9);
        chk("wr_bus_vld", bus_vld, 1);
        chk("wr_bus_we", bus_we, 1);
        chk("wr_bus_adr", bus_adr, 32'h12345678);
        chk("wr_bus_dat", bus_dat, 32'hDEADBEEF);
        chk("wr_str_rdy_low", str_rdy, 0);
        tick();
        chk("wr_bus_vld_off", bus_vld, 0);
        chk("wr_str_rdy_back", str_rdy, 1);
        bus_rdy = 1'b0;

        // Read with 3 wait cycles on the bus
        send_a(40'h8000000401, 5);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                bus_rdy = 1'b1;
                bus_rdt = 32'hCAFEF00D;
            end
            chk("rd_bus_vld", bus_vld, 1);
            chk("rd_bus_we", bus_we, 0);
            chk("rd_bus_adr", bus_adr, 32'h80000004);
            tick();
        end
        bus_rdy = 1'b0;
        chk("rd_bus_vld_off", bus_vld, 0);
        rsp_rdy = 1'b1;
        ev = 64'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            chk("rd_rsp_vld", rsp_vld, 1);
            chk("rd_rsp_bus", rsp_bus, ev[8*k +: 8]);
            chk("rd_str_rdy_low", str_rdy, 0);
            tick();
        end
        chk("rd_rsp_vld_end", rsp_vld, 0);
        chk("rd_str_rdy_back", str_rdy, 1);
        rsp_rdy = 1'b0;

        // Read with upper command bits set and response backpressure
        send_a(40'h40302010FD, 5);
        chk("bp_bus_we", bus_we, 0);
        chk("bp_bus_adr", bus_adr, 32'h40302010);
        chk("bp_dat_hold", bus_dat, 32'hDEADBEEF);
        bus_rdy = 1'b1;
        bus_rdt = 32'h11223344;
        tick();
        bus_rdy = 1'b0;
        ev = 64'h11223344;
        for (int c = 0; c < 8; c++) begin
            rsp_rdy = c[0];
            chk("bp_rsp_vld", rsp_vld, 1);
            chk("bp_rsp_bus", rsp_bus, ev[8*(c/2) +: 8]);
            tick();
        end
        chk("bp_rsp_vld_end", rsp_vld, 0);
        chk("bp_str_rdy_back", str_rdy, 1);
        rsp_rdy = 1'b0;

        // Illegal opcode then a normal write
        send_a(128'h02, 1);
        chk("ill_err", err, 1);
        chk("ill_str_rdy", str_rdy, 1);
        chk("ill_bus_vld", bus_vld, 0);
        tick();
        chk("ill_err_clear", err, 0);
        bus_rdy = 1'b1;
        send_a(72'hDEADBEEF1234567800, 9);
        chk("ill_wr_bus_vld", bus_vld, 1);
        chk("ill_wr_bus_we", bus_we, 1);
        chk("ill_wr_bus_adr", bus_adr, 32'h12345678);
        chk("ill_wr_bus_dat", bus_dat, 32'hDEADBEEF);
        tick();
        chk("ill_wr_str_rdy", str_rdy, 1);

        // Reset after 3 address beats of a write
        send_a(32'h33221100, 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_bus_vld", bus_vld, 0);
        chk("mid_rst_str_rdy", str_rdy, 1);
        chk("mid_rst_bus_adr", bus_adr, 0);
        tick();
        rst = 1'b1;
        bus_rdy = 1'b0;
        seen_vld = 1'b0;
        tick();
        send_a(40'hDDCCBBAA01, 5);
        chk("mid_no_early_vld", seen_vld, 0);
        chk("mid_rd_bus_vld", bus_vld, 1);
        chk("mid_rd_bus_we", bus_we, 0);
        chk("mid_rd_bus_adr", bus_adr, 32'hDDCCBBAA);
        chk("mid_rd_bus_dat", bus_dat, 0);
        bus_rdy = 1'b1;
        bus_rdt = 32'h01020304;
        tick();
        bus_rdy = 1'b0;
        rsp_rdy = 1'b1;
        ev = 64'h01020304;
        for (int k = 0; k < 4; k++) begin
            chk("mid_rsp_vld", rsp_vld, 1);
            chk("mid_rsp_bus", rsp_bus, ev[8*k +: 8]);
            tick();
        end
        chk("mid_rsp_vld_end", rsp_vld, 0);
        rsp_rdy = 1'b0;

        // Wide instance: SW=16, AW=16, DW=64
        w_bus_rdy = 1'b1;
        send_b(96'h000011112222333300BEEF0000 & 96'h0000111122223333BEEF0000 | 96'h0000111122223333BEEF0000, 6);
        chk("w_wr_bus_vld", w_bus_vld, 1);
        chk("w_wr_bus_we", w_bus_we, 1);
        chk("w_wr_bus_adr", w_bus_adr, 16'hBEEF);
        chk("w_wr_bus_dat", w_bus_dat, 64'h0000111122223333);
        tick();
        chk("w_wr_bus_vld_off", w_bus_vld, 0);
        chk("w_wr_str_rdy", w_str_rdy, 1);
        w_bus_rdy = 1'b0;
        send_b(32'h12340001, 2);
        chk("w_rd_bus_vld", w_bus_vld, 1);
        chk("w_rd_bus_we", w_bus_we, 0);
        chk("w_rd_bus_adr", w_bus_adr, 16'h1234);
        w_bus_rdy = 1'b1;
        w_bus_rdt = 64'h0123456789ABCDEF;
        tick();
        w_bus_rdy = 1'b0;
        w_rsp_rdy = 1'b1;
        ev = 64'h0123456789ABCDEF;
        for (int k = 0; k < 4; k++) begin
            chk("w_rsp_vld", w_rsp_vld, 1);
            chk("w_rsp_bus", w_rsp_bus, ev[16*k +: 16]);
            tick();
        end
        chk("w_rsp_vld_end", w_rsp_vld, 0);
        chk("w_str_rdy_back", w_str_rdy, 1);
        w_rsp_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
